// File: rtl/uart_tx_feeder.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_feeder
// Purpose  : Byte FIFO plus a sequencer that writes each byte into the UART.
//            Optional start timeout is enabled with UART_TX_FEEDER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_feeder #(
  parameter int DEPTH         = 16,
  parameter int START_TIMEOUT = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [7:0]                   push_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  input  logic                         clr_err,
  output logic                         overflow,
  output logic                         timeout_err,
  output logic [3:0]                   uart_addr,
  output logic [31:0]                  uart_wdata,
  output logic                         uart_we,
  input  logic                         uart_busy
);

  localparam int c_addr_w = $clog2(DEPTH);
  localparam int c_cnt_w  = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WR_DATA    = 3'd1,
    S_WR_CMD     = 3'd2,
    S_WAIT_START = 3'd3,
    S_WAIT_DONE  = 3'd4
  } state_t;

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || START_TIMEOUT < 1) begin : g_bad_params
      $error("uart_tx_feeder: DEPTH must be a power of two >= 2, START_TIMEOUT >= 1");
    end
  endgenerate

  logic [7:0]          r_mem [DEPTH];
  logic [c_addr_w-1:0] r_wr_ptr;
  logic [c_addr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0]  r_count;
  logic                r_overflow;
  state_t              r_state;
  logic                r_uart_we;
  logic [3:0]          r_uart_addr;
  logic [31:0]         r_uart_wdata;
  logic                w_pop;
  logic                w_push_ok;
  logic                w_timeout;

  assign full        = (r_count == c_cnt_w'(DEPTH));
  assign empty       = (r_count == '0);
  assign count       = r_count;
  assign overflow    = r_overflow;
  assign uart_we     = r_uart_we;
  assign uart_addr   = r_uart_addr;
  assign uart_wdata  = r_uart_wdata;

  // The head byte leaves the FIFO in the same cycle it is written to the UART,
  // which frees a slot for a push arriving while full.
  assign w_pop     = (r_state == S_WR_DATA);
  assign w_push_ok = push && (!full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_addr_w'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + c_addr_w'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
      if (push && full && !w_pop) r_overflow <= 1'b1;
      else if (clr_err)           r_overflow <= 1'b0;
    end
  end

`ifdef UART_TX_FEEDER_TIMEOUT_EN
  localparam int c_to_w = ($clog2(START_TIMEOUT + 1) > 8) ? $clog2(START_TIMEOUT + 1) : 8;

  logic [c_to_w-1:0] r_to_cnt;
  logic              r_timeout_err;

  assign w_timeout   = (r_state == S_WAIT_START) && !uart_busy &&
                       (r_to_cnt == c_to_w'(START_TIMEOUT - 1));
  assign timeout_err = r_timeout_err;

  // Held at zero outside WAIT_START, so every entry starts a fresh count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state != S_WAIT_START) r_to_cnt <= '0;
      else                         r_to_cnt <= r_to_cnt + c_to_w'(1);
      if (w_timeout)    r_timeout_err <= 1'b1;
      else if (clr_err) r_timeout_err <= 1'b0;
    end
  end
`else
  assign w_timeout   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_uart_we    <= 1'b0;
      r_uart_addr  <= 4'd0;
      r_uart_wdata <= 32'd0;
    end else begin
      r_uart_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!empty && !uart_busy) r_state <= S_WR_DATA;
        end
        S_WR_DATA: begin
          r_uart_we    <= 1'b1;
          r_uart_addr  <= 4'd1;
          r_uart_wdata <= {24'd0, r_mem[r_rd_ptr]};
          r_state      <= S_WR_CMD;
        end
        S_WR_CMD: begin
          r_uart_we    <= 1'b1;
          r_uart_addr  <= 4'd0;
          r_uart_wdata <= 32'd1;
          r_state      <= S_WAIT_START;
        end
        S_WAIT_START: begin
          if (uart_busy)      r_state <= S_WAIT_DONE;
          else if (w_timeout) r_state <= S_IDLE;
        end
        S_WAIT_DONE: begin
          if (!uart_busy) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_feeder
// Purpose  : Directed self-checking bench for uart_tx_feeder with a UART model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_feeder;

  logic        clk;
  logic        rst_n;
  logic        push;
  logic [7:0]  push_data;
  logic        full;
  logic        empty;
  logic [4:0]  count;
  logic        clr_err;
  logic        overflow;
  logic        timeout_err;
  logic [3:0]  uart_addr;
  logic [31:0] uart_wdata;
  logic        uart_we;
  logic        uart_busy;

  int n_checks = 0;
  int n_fail   = 0;

  // UART model: busy rises on the edge after the command strobe and holds busy_len cycles
  logic model_en  = 1'b1;
  logic hold_busy = 1'b0;
  int   busy_len  = 100;
  int   busy_cnt;
  int   viol = 0;
  logic [35:0] wlog [$];

  uart_tx_feeder #(.DEPTH(16), .START_TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .push_data(push_data),
    .full(full), .empty(empty), .count(count), .clr_err(clr_err),
    .overflow(overflow), .timeout_err(timeout_err), .uart_addr(uart_addr),
    .uart_wdata(uart_wdata), .uart_we(uart_we), .uart_busy(uart_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       busy_cnt <= 0;
    else if (model_en && uart_we && uart_addr == 4'd0) busy_cnt <= busy_len;
    else if (busy_cnt != 0)                           busy_cnt <= busy_cnt - 1;
  end
  assign uart_busy = hold_busy | (busy_cnt != 0);

  always @(negedge clk) begin
    if (rst_n && uart_we) begin
      wlog.push_back({uart_addr, uart_wdata});
      if (uart_busy) viol <= viol + 1;
    end
  end

  task automatic wait_log(input int n, input int budget, input string tag);
    int k = 0;
    while (wlog.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (wlog.size() < n) begin
      n_fail++;
      $display("FAIL %s: got %0d writes, expected %0d", tag, wlog.size(), n);
    end
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    repeat (3) @(negedge clk);
    while (uart_busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (uart_busy) begin
      n_fail++;
      $display("FAIL %s: busy still %b, expected 0", tag, uart_busy);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; push = 1'b0; push_data = 8'h00; clr_err = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (count !== 5'd0)      begin n_fail++; $display("FAIL rst_count: got %0d expected 0", count); end
    n_checks++; if (empty !== 1'b1)      begin n_fail++; $display("FAIL rst_empty: got %b expected 1", empty); end
    n_checks++; if (full !== 1'b0)       begin n_fail++; $display("FAIL rst_full: got %b expected 0", full); end
    n_checks++; if (overflow !== 1'b0)   begin n_fail++; $display("FAIL rst_overflow: got %b expected 0", overflow); end
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL rst_timeout: got %b expected 0", timeout_err); end
    n_checks++; if ({uart_we, uart_addr, uart_wdata} !== 37'd0) begin
      n_fail++; $display("FAIL rst_uart: got we=%b addr=%0h wdata=%0h expected all 0", uart_we, uart_addr, uart_wdata);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_byte();
    model_en = 1'b1; busy_len = 100;
    @(negedge clk); push = 1'b1; push_data = 8'h41;
    @(posedge clk); #1;
    n_checks++; if (count !== 5'd1 || uart_we !== 1'b0) begin
      n_fail++; $display("FAIL single_e0: got count=%0d we=%b expected 1/0", count, uart_we);
    end
    @(negedge clk); push = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (uart_we !== 1'b0) begin n_fail++; $display("FAIL single_e1: got we=%b expected 0", uart_we); end
    @(posedge clk); #1;
    n_checks++; if ({uart_we, uart_addr, uart_wdata} !== {1'b1, 4'd1, 32'h41}) begin
      n_fail++; $display("FAIL single_data: got we=%b addr=%0h wdata=%0h expected 1/1/41", uart_we, uart_addr, uart_wdata);
    end
    n_checks++; if (count !== 5'd0 || empty !== 1'b1) begin
      n_fail++; $display("FAIL single_pop: got count=%0d empty=%b expected 0/1", count, empty);
    end
    @(posedge clk); #1;
    n_checks++; if ({uart_we, uart_addr, uart_wdata} !== {1'b1, 4'd0, 32'h1}) begin
      n_fail++; $display("FAIL single_cmd: got we=%b addr=%0h wdata=%0h expected 1/0/1", uart_we, uart_addr, uart_wdata);
    end
    @(posedge clk); #1;
    n_checks++; if (uart_we !== 1'b0) begin n_fail++; $display("FAIL single_e4: got we=%b expected 0", uart_we); end
    wait_idle(200, "single_idle");
  endtask

  task automatic test_back_to_back();
    logic [35:0] exp [6];
    int b = wlog.size();
    int v0 = viol;
    exp = '{{4'd1, 32'h10}, {4'd0, 32'h1}, {4'd1, 32'h20}, {4'd0, 32'h1}, {4'd1, 32'h30}, {4'd0, 32'h1}};
    busy_len = 20;
    @(negedge clk); push = 1'b1; push_data = 8'h10;
    @(negedge clk); push_data = 8'h20;
    @(negedge clk); push_data = 8'h30;
    @(negedge clk); push = 1'b0;
    wait_log(b + 6, 400, "b2b_writes");
    for (int i = 0; i < 6; i++) begin
      if (b + i < wlog.size()) begin
        n_checks++;
        if (wlog[b + i] !== exp[i]) begin
          n_fail++; $display("FAIL b2b_entry%0d: got %0h expected %0h", i, wlog[b + i], exp[i]);
        end
      end
    end
    wait_idle(100, "b2b_idle");
    n_checks++; if (viol !== v0) begin n_fail++; $display("FAIL b2b_we_busy: got %0d writes while busy expected 0", viol - v0); end
  endtask

  task automatic test_overflow();
    int b = wlog.size();
    @(negedge clk); hold_busy = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (i == 16) begin
        n_checks++; if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b0) begin
          n_fail++; $display("FAIL ovf_full: got full=%b count=%0d ovf=%b expected 1/16/0", full, count, overflow);
        end
      end
      push = 1'b1; push_data = 8'h80 + 8'(i);
    end
    @(negedge clk); push = 1'b0;
    n_checks++; if (overflow !== 1'b1 || count !== 5'd16) begin
      n_fail++; $display("FAIL ovf_set: got ovf=%b count=%0d expected 1/16", overflow, count);
    end
    n_checks++; if (wlog.size() !== b) begin n_fail++; $display("FAIL ovf_no_write: got %0d writes expected 0", wlog.size() - b); end
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clr: got %b expected 0", overflow); end
  endtask

  task automatic test_full_pop();
    int b = wlog.size();
    busy_len = 3;
    @(negedge clk); hold_busy = 1'b0;
    @(negedge clk); push = 1'b1; push_data = 8'hEE;
    @(posedge clk); #1;
    n_checks++; if (count !== 5'd16 || uart_we !== 1'b1 || uart_wdata !== 32'h80) begin
      n_fail++; $display("FAIL fp_pop: got count=%0d we=%b wdata=%0h expected 16/1/80", count, uart_we, uart_wdata);
    end
    @(negedge clk); push = 1'b0;
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fp_ovf: got %b expected 0", overflow); end
    wait_log(b + 34, 1500, "fp_writes");
    for (int i = 0; i < 17; i++) begin
      logic [35:0] e;
      e = (i == 16) ? {4'd1, 32'hEE} : {4'd1, 24'd0, 8'h80 + 8'(i)};
      if (b + 2 * i + 1 < wlog.size()) begin
        n_checks++;
        if (wlog[b + 2 * i] !== e || wlog[b + 2 * i + 1] !== {4'd0, 32'h1}) begin
          n_fail++; $display("FAIL fp_byte%0d: got %0h/%0h expected %0h/000000001", i, wlog[b + 2 * i], wlog[b + 2 * i + 1], e);
        end
      end
    end
    wait_idle(100, "fp_idle");
  endtask

  task automatic test_timeout();
    int b = wlog.size();
    int k = 0;
    model_en = 1'b0;
`ifdef UART_TX_FEEDER_TIMEOUT_EN
    @(negedge clk); push = 1'b1; push_data = 8'h55;
    @(negedge clk); push_data = 8'h66;
    @(negedge clk); push = 1'b0;
    wait_log(b + 2, 20, "to_first");
    repeat (57) @(negedge clk);
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_early: got %b expected 0", timeout_err); end
    while (timeout_err !== 1'b1 && k < 15) begin @(negedge clk); k++; end
    n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_set: got %b expected 1", timeout_err); end
    wait_log(b + 3, 10, "to_next");
    if (wlog.size() > b + 2) begin
      n_checks++; if (wlog[b + 2] !== {4'd1, 32'h66}) begin
        n_fail++; $display("FAIL to_next_byte: got %0h expected 100000066", wlog[b + 2]);
      end
    end
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_clr: got %b expected 0", timeout_err); end
`else
    @(negedge clk); push = 1'b1; push_data = 8'h55;
    @(negedge clk); push = 1'b0;
    wait_log(b + 2, 20, "nto_first");
    repeat (100) @(negedge clk);
    n_checks++; if (timeout_err !== 1'b0 || wlog.size() !== b + 2) begin
      n_fail++; $display("FAIL nto_wait: got err=%b writes=%0d expected 0/2", timeout_err, wlog.size() - b);
    end
`endif
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1; model_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int b;
    busy_len = 100;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); push = 1'b1; push_data = 8'hA0 + 8'(i);
    end
    @(negedge clk); push = 1'b0;
    repeat (15) @(negedge clk);
    n_checks++; if (count !== 5'd5 || uart_busy !== 1'b1) begin
      n_fail++; $display("FAIL rm_pre: got count=%0d busy=%b expected 5/1", count, uart_busy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (count !== 5'd0 || empty !== 1'b1 || uart_we !== 1'b0) begin
      n_fail++; $display("FAIL rm_async: got count=%0d empty=%b we=%b expected 0/1/0", count, empty, uart_we);
    end
    repeat (2) @(negedge clk);
    b = wlog.size();
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    n_checks++; if (wlog.size() !== b) begin n_fail++; $display("FAIL rm_quiet: got %0d writes expected 0", wlog.size() - b); end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
